// File: rtl/dcache_tag_ctrl.sv
// Tag SRAM front-end: clears all sets after reset, then lookups answer 2 cycles after acceptance.
// Responses stall via a one-entry skid; optional DCACHE_TAG_FLUSH_EN adds flush_req/flush_done.
`timescale 1ns/1ps
module dcache_tag_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 5,
  parameter int INDEX_WIDTH  = 4,
  parameter int SRAM_WIDTH   = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_vbit,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_hit,
  output logic [SRAM_WIDTH-2:0]   resp_tag,
  output logic                    resp_vbit,
  output logic                    sram_csb,
  output logic                    sram_web,
  output logic [INDEX_WIDTH-1:0]  sram_addr,
  output logic [SRAM_WIDTH-1:0]   sram_din,
  input  logic [SRAM_WIDTH-1:0]   sram_dout
`ifdef DCACHE_TAG_FLUSH_EN
  ,
  input  logic                    flush_req,
  output logic                    flush_done
`endif
);

  localparam int TAG_W   = SRAM_WIDTH - 1;
  localparam int TAG_LSB = OFFSET_WIDTH + INDEX_WIDTH;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic             hit;
    logic [TAG_W-1:0] tag;
    logic             vbit;
  } resp_t;

  logic [0:0]             state;
  logic [INDEX_WIDTH-1:0] cnt;
  logic                   init_active;

  logic [TAG_W-1:0]       req_tag;
  logic [INDEX_WIDTH-1:0] req_idx;
  logic                   accept;
  logic                   resp_free;
  logic                   req_block;
  logic                   flush_go;

  logic                   s1_vld;
  logic [TAG_W-1:0]       s1_tag;
  resp_t                  s1_res;
  logic                   skid_vld;
  resp_t                  skid_dat;
  logic                   resp_vld;
  resp_t                  resp_dat;

  logic                   unused_offset;

  assign req_tag       = req_addr[ADDR_WIDTH-1:TAG_LSB];
  assign req_idx       = req_addr[TAG_LSB-1:OFFSET_WIDTH];
  assign unused_offset = ^req_addr[OFFSET_WIDTH-1:0];

  assign init_active = (state == ST_INIT);
  assign resp_free   = !resp_vld || resp_ready;
  assign req_ready   = (state == ST_RUN) && !req_block && !skid_vld && resp_free;
  assign accept      = req_valid && req_ready;

`ifdef DCACHE_TAG_FLUSH_EN
  logic flush_pend;
  logic flush_want;

  // New requests are held off while a flush waits, so the pipeline is guaranteed to empty.
  assign flush_want = flush_pend || flush_req;
  assign req_block  = flush_want;
  assign flush_go   = (state == ST_RUN) && flush_want && !s1_vld && !skid_vld && !resp_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= init_active && (cnt == '1);
      if (flush_go)
        flush_pend <= 1'b0;
      else if ((state == ST_RUN) && flush_req)
        flush_pend <= 1'b1;
    end
  end
`else
  assign req_block = 1'b0;
  assign flush_go  = 1'b0;
`endif

  // Pins are combinational so the macro samples the request on its acceptance edge.
  always_comb begin
    sram_csb  = 1'b1;
    sram_web  = 1'b1;
    sram_addr = '0;
    sram_din  = '0;
    if (rst_n) begin
      if (init_active) begin
        sram_csb  = 1'b0;
        sram_web  = 1'b0;
        sram_addr = cnt;
      end else if (accept) begin
        sram_csb  = 1'b0;
        sram_web  = !req_write;
        sram_addr = req_idx;
        sram_din  = {req_vbit, req_tag};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1)
            state <= ST_RUN;
        end
        default: begin
          if (flush_go) begin
            state <= ST_INIT;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    s1_res.vbit = sram_dout[SRAM_WIDTH-1];
    s1_res.tag  = sram_dout[TAG_W-1:0];
    s1_res.hit  = sram_dout[SRAM_WIDTH-1] && (sram_dout[TAG_W-1:0] == s1_tag);
  end

  // s1 and skid are never both occupied: a skid load implies no acceptance on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_tag   <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
      resp_vld <= 1'b0;
      resp_dat <= '0;
    end else begin
      s1_vld <= accept && !req_write;
      if (accept && !req_write)
        s1_tag <= req_tag;

      if (resp_free) begin
        if (skid_vld) begin
          resp_vld <= 1'b1;
          resp_dat <= skid_dat;
          skid_vld <= s1_vld;
          if (s1_vld)
            skid_dat <= s1_res;
        end else if (s1_vld) begin
          resp_vld <= 1'b1;
          resp_dat <= s1_res;
        end else begin
          resp_vld <= 1'b0;
        end
      end else if (s1_vld) begin
        skid_vld <= 1'b1;
        skid_dat <= s1_res;
      end
    end
  end

  assign resp_valid = resp_vld;
  assign resp_hit   = resp_dat.hit;
  assign resp_tag   = resp_dat.tag;
  assign resp_vbit  = resp_dat.vbit;

endmodule
